// File: rtl/run_controller_if.sv
// Start/Ack handshake and combinational data-memory read port shared by
// run_controller (master) and the processor/memory side (slave).
interface run_controller_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          Start;
  logic          Ack;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemRdData;

  modport master (output Start, output MemAddr, input Ack, input MemRdData);
  modport slave  (input Start, input MemAddr, output Ack, output MemRdData);
endinterface

// File: rtl/run_controller.sv
// Host-side launcher for the processor: pulses Start, times the wait for Ack
// (with stale-Ack rejection and timeout), then reads NRD result words back.
module run_controller #(
  parameter int          DW           = 8,
  parameter int          AW           = 8,
  parameter int          NRD          = 4,
  parameter int          RD_BASE      = 0,
  parameter int          START_CYCLES = 1,
  parameter int          TW           = 16,
  parameter int unsigned TIMEOUT      = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  run_controller_if.master  bus,
  output logic [NRD*DW-1:0] Result,
  output logic [TW-1:0]     CycleCount,
  output logic              Busy,
  output logic              Done,
  output logic              TimedOut
);

  localparam int IW = (NRD > 1) ? $clog2(NRD) : 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [AW-1:0] BASE      = AW'(RD_BASE);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NRD - 1);
  localparam logic [SW-1:0] LAST_SCNT = SW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TMO       = TW'(TIMEOUT);
  localparam logic [TW-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACK, S_READ, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [SW-1:0]     start_cnt_q, start_cnt_d;
  logic              armed_q, armed_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [NRD*DW-1:0] result_q, result_d;
  logic [TW-1:0]     cycle_q, cycle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic [TW-1:0]     cycle_inc;

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    start_cnt_d = start_cnt_q;
    armed_d     = armed_q;
    idx_d       = idx_q;
    mem_addr_d  = BASE;
    result_d    = result_q;
    cycle_d     = cycle_q;
    busy_d      = busy_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    cycle_inc   = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + TW'(1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_d     = S_LAUNCH;
          start_d     = 1'b1;
          start_cnt_d = '0;
          armed_d     = 1'b0;
          result_d    = '0;
          cycle_d     = '0;
          timed_out_d = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (start_cnt_q == LAST_SCNT) begin
          start_d = 1'b0;
          state_d = S_WAIT_ACK;
        end else begin
          start_cnt_d = start_cnt_q + SW'(1);
        end
      end
      S_WAIT_ACK: begin
        // An Ack only counts once a low has been seen, so a level left over
        // from the previous run cannot end this one; Ack beats a same-cycle timeout.
        if (armed_q && bus.Ack) begin
          state_d = S_READ;
          idx_d   = '0;
        end else begin
          if (!bus.Ack) armed_d = 1'b1;
          cycle_d = cycle_inc;
          if (cycle_inc >= TMO) begin
            state_d     = S_DONE;
            timed_out_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      S_READ: begin
        for (int i = 0; i < NRD; i++) begin
          if (idx_q == IW'(i)) result_d[(NRD-1-i)*DW +: DW] = bus.MemRdData;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_q + IW'(1);
          mem_addr_d = mem_addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      start_cnt_q <= '0;
      armed_q     <= 1'b0;
      idx_q       <= '0;
      mem_addr_q  <= BASE;
      result_q    <= '0;
      cycle_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      start_cnt_q <= start_cnt_d;
      armed_q     <= armed_d;
      idx_q       <= idx_d;
      mem_addr_q  <= mem_addr_d;
      result_q    <= result_d;
      cycle_q     <= cycle_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.Start   = start_q;
  assign bus.MemAddr = mem_addr_q;
  assign Result      = result_q;
  assign CycleCount  = cycle_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign TimedOut    = timed_out_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: two instances (base 0 and base FE),
// shared memory model, per-scenario tasks with inline comparisons.
module tb_run_controller;
  localparam int DW = 8, AW = 8, NRD = 4, TW = 16, TMO = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic go_a = 1'b0, go_b = 1'b0;
  logic [NRD*DW-1:0] result_a, result_b;
  logic [TW-1:0]     cc_a, cc_b;
  logic busy_a, busy_b, done_a, done_b, to_a, to_b;
  logic [DW-1:0] mem [256];

  int tests = 0;
  int fails = 0;
  logic [AW-1:0]     exp_addr_q [$];
  logic [NRD*DW-1:0] exp_res_q  [$];

  run_controller_if #(.DW(DW), .AW(AW)) bus_a ();
  run_controller_if #(.DW(DW), .AW(AW)) bus_b ();

  assign bus_a.MemRdData = mem[bus_a.MemAddr];
  assign bus_b.MemRdData = mem[bus_b.MemAddr];

  run_controller #(.DW(DW), .AW(AW), .NRD(NRD), .RD_BASE(0), .START_CYCLES(1),
                   .TW(TW), .TIMEOUT(TMO)) dut_a (
    .Clk(clk), .Reset(rst_n), .Go(go_a), .bus(bus_a.master), .Result(result_a),
    .CycleCount(cc_a), .Busy(busy_a), .Done(done_a), .TimedOut(to_a));

  run_controller #(.DW(DW), .AW(AW), .NRD(NRD), .RD_BASE(8'hFE), .START_CYCLES(1),
                   .TW(TW), .TIMEOUT(TMO)) dut_b (
    .Clk(clk), .Reset(rst_n), .Go(go_b), .bus(bus_b.master), .Result(result_b),
    .CycleCount(cc_b), .Busy(busy_b), .Done(done_b), .TimedOut(to_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic push_expect(input logic [AW-1:0] base);
    logic [AW-1:0]     a;
    logic [NRD*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NRD; i++) begin
      a = base + AW'(i);
      exp_addr_q.push_back(a);
      r = (r << DW) | (NRD*DW)'(mem[a]);
    end
    exp_res_q.push_back(r);
  endtask

  // Call right after the accepting edge: walks the READ cycles against the scoreboard.
  task automatic read_check(input bit sel);
    logic [AW-1:0]     a, ea;
    logic [NRD*DW-1:0] r, er;
    for (int i = 0; i < NRD; i++) begin
      a  = sel ? bus_b.MemAddr : bus_a.MemAddr;
      ea = exp_addr_q.pop_front();
      tests++; if (a !== ea) begin fails++; $display("[TB] FAIL read_addr[%0d]: got %h, expected %h", i, a, ea); end
      tests++; if ((sel ? busy_b : busy_a) !== 1'b1 || (sel ? done_b : done_a) !== 1'b0) begin
        fails++; $display("[TB] FAIL read_busy[%0d]: busy/done got %b%b, expected 10", i, sel ? busy_b : busy_a, sel ? done_b : done_a);
      end
      tick();
    end
    r  = sel ? result_b : result_a;
    er = exp_res_q.pop_front();
    tests++; if (r !== er) begin fails++; $display("[TB] FAIL result: got %h, expected %h", r, er); end
    tests++; if ((sel ? busy_b : busy_a) !== 1'b0 || (sel ? done_b : done_a) !== 1'b1 || (sel ? to_b : to_a) !== 1'b0) begin
      fails++; $display("[TB] FAIL done_flags: busy/done/to got %b%b%b, expected 010", sel ? busy_b : busy_a, sel ? done_b : done_a, sel ? to_b : to_a);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    go_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus_a.Start !== 1'b0) begin fails++; $display("[TB] FAIL rst_start: got %b, expected 0", bus_a.Start); end
      tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || to_a !== 1'b0) begin fails++; $display("[TB] FAIL rst_flags: got %b%b%b, expected 000", busy_a, done_a, to_a); end
      tests++; if (result_a !== '0 || cc_a !== '0) begin fails++; $display("[TB] FAIL rst_data: got %h/%h, expected 0/0", result_a, cc_a); end
      tests++; if (bus_a.MemAddr !== 8'h00 || bus_b.MemAddr !== 8'hFE) begin fails++; $display("[TB] FAIL rst_addr: got %h/%h, expected 00/fe", bus_a.MemAddr, bus_b.MemAddr); end
    end
    rst_n = 1'b1;
    tick();
    tests++; if (bus_a.Start !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_start: got %b, expected 1", bus_a.Start); end
    go_a = 1'b0;
    tick();
    tests++; if (bus_a.Start !== 1'b0) begin fails++; $display("[TB] FAIL start_width: got %b, expected 0", bus_a.Start); end
    do_reset();
  endtask

  task automatic test_normal();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    bus_a.Ack = 1'b1;
    push_expect(8'h00);
    go_a = 1'b1;
    tick();
    tests++; if (bus_a.Start !== 1'b1 || busy_a !== 1'b1) begin fails++; $display("[TB] FAIL launch: start/busy got %b%b, expected 11", bus_a.Start, busy_a); end
    go_a = 1'b0; bus_a.Ack = 1'b0;
    tick();
    tests++; if (bus_a.Start !== 1'b0) begin fails++; $display("[TB] FAIL start_fall: got %b, expected 0", bus_a.Start); end
    repeat (20) tick();
    bus_a.Ack = 1'b1;
    tick();
    tests++; if (cc_a !== 16'd20) begin fails++; $display("[TB] FAIL normal_cc: got %0d, expected 20", cc_a); end
    read_check(1'b0);
    tests++; if (cc_a !== 16'd20 || bus_a.MemAddr !== 8'h00) begin fails++; $display("[TB] FAIL normal_hold: cc/addr got %0d/%h, expected 20/00", cc_a, bus_a.MemAddr); end
  endtask

  task automatic test_timeout();
    bus_a.Ack = 1'b0;
    go_a = 1'b1;
    tick();
    tests++; if (result_a !== '0 || cc_a !== '0 || done_a !== 1'b0) begin fails++; $display("[TB] FAIL relaunch_clear: res/cc/done got %h/%0d/%b, expected 0/0/0", result_a, cc_a, done_a); end
    go_a = 1'b0;
    tick();
    for (int i = 0; i < TMO; i++) begin
      tests++; if (done_a !== 1'b0 || cc_a !== TW'(i) || bus_a.MemAddr !== 8'h00) begin
        fails++; $display("[TB] FAIL tmo_wait[%0d]: done/cc/addr got %b/%0d/%h, expected 0/%0d/00", i, done_a, cc_a, bus_a.MemAddr, i);
      end
      tick();
    end
    tests++; if (done_a !== 1'b1 || to_a !== 1'b1 || busy_a !== 1'b0) begin fails++; $display("[TB] FAIL tmo_flags: done/to/busy got %b%b%b, expected 110", done_a, to_a, busy_a); end
    tests++; if (cc_a !== TW'(TMO) || result_a !== '0 || bus_a.MemAddr !== 8'h00) begin fails++; $display("[TB] FAIL tmo_data: cc/res/addr got %0d/%h/%h, expected 50/0/00", cc_a, result_a, bus_a.MemAddr); end
  endtask

  task automatic test_stale_ack();
    bus_a.Ack = 1'b1;
    push_expect(8'h00);
    go_a = 1'b1;
    tick();
    tests++; if (to_a !== 1'b0) begin fails++; $display("[TB] FAIL stale_to_clear: got %b, expected 0", to_a); end
    go_a = 1'b0;
    tick();
    repeat (5) tick();
    tests++; if (cc_a !== 16'd5 || bus_a.MemAddr !== 8'h00) begin fails++; $display("[TB] FAIL stale_reject: cc/addr got %0d/%h, expected 5/00", cc_a, bus_a.MemAddr); end
    bus_a.Ack = 1'b0;
    repeat (3) tick();
    bus_a.Ack = 1'b1;
    tick();
    tests++; if (cc_a !== 16'd8) begin fails++; $display("[TB] FAIL stale_cc: got %0d, expected 8", cc_a); end
    read_check(1'b0);
  endtask

  task automatic test_back_to_back();
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2;
    bus_b.Ack = 1'b0;
    push_expect(8'hFE);
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    tick();
    repeat (3) tick();
    go_b = 1'b1;
    tick();
    tests++; if (bus_b.Start !== 1'b0 || cc_b !== 16'd4) begin fails++; $display("[TB] FAIL go_ignored: start/cc got %b/%0d, expected 0/4", bus_b.Start, cc_b); end
    go_b = 1'b0;
    repeat (2) tick();
    bus_b.Ack = 1'b1;
    tick();
    tests++; if (cc_b !== 16'd6) begin fails++; $display("[TB] FAIL wrap_cc: got %0d, expected 6", cc_b); end
    read_check(1'b1);
    mem[8'hFE] = 8'h5A;
    push_expect(8'hFE);
    go_b = 1'b1;
    tick();
    tests++; if (result_b !== '0 || cc_b !== '0 || done_b !== 1'b0 || bus_b.Start !== 1'b1) begin
      fails++; $display("[TB] FAIL rerun_clear: res/cc/done/start got %h/%0d/%b/%b, expected 0/0/0/1", result_b, cc_b, done_b, bus_b.Start);
    end
    go_b = 1'b0; bus_b.Ack = 1'b0;
    tick();
    repeat (2) tick();
    bus_b.Ack = 1'b1;
    tick();
    tests++; if (cc_b !== 16'd2) begin fails++; $display("[TB] FAIL rerun_cc: got %0d, expected 2", cc_b); end
    read_check(1'b1);
  endtask

  task automatic test_reset_mid_run();
    logic [NRD*DW-1:0] part;
    part = {mem[0], mem[1], {(NRD-2)*DW{1'b0}}};
    go_a = 1'b1;
    tick();
    go_a = 1'b0; bus_a.Ack = 1'b0;
    tick();
    repeat (2) tick();
    bus_a.Ack = 1'b1;
    tick();
    tick(); tick();
    tests++; if (result_a !== part || bus_a.MemAddr !== 8'h02) begin fails++; $display("[TB] FAIL mid_read: res/addr got %h/%h, expected %h/02", result_a, bus_a.MemAddr, part); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (result_a !== '0 || cc_a !== '0 || bus_a.MemAddr !== 8'h00) begin fails++; $display("[TB] FAIL async_rst_data: res/cc/addr got %h/%0d/%h, expected 0/0/00", result_a, cc_a, bus_a.MemAddr); end
    tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || to_a !== 1'b0) begin fails++; $display("[TB] FAIL async_rst_flags: got %b%b%b, expected 000", busy_a, done_a, to_a); end
    tick();
    rst_n = 1'b1;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    tests++; if (bus_a.Start !== 1'b0) begin fails++; $display("[TB] FAIL async_start_drop: got %b, expected 0", bus_a.Start); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (busy_a !== 1'b0 || bus_a.Start !== 1'b0 || done_a !== 1'b0) begin fails++; $display("[TB] FAIL idle_hold[%0d]: busy/start/done got %b%b%b, expected 000", i, busy_a, bus_a.Start, done_a); end
    end
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    tests++; if (bus_a.Start !== 1'b1) begin fails++; $display("[TB] FAIL idle_go: got %b, expected 1", bus_a.Start); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'(i ^ 8'h3C);
    bus_a.Ack = 1'b0;
    bus_b.Ack = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_stale_ack();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
